k007232_mixer: RTL and testbench

- Downstream stage of the k007232 PCM core.
- Consumes the two 7-bit channel sample buses (ASD, BSD) and the SLEV volume-write strobe with the DB byte.
- Applies per-channel 4-bit volume with zipper-free ramping, sums both channels and applies gain.
- Produces one registered signed mixed sample per sample strobe for the board DAC/filter stage.

---
 rtl/k007232_mixer.sv | 138 +++++++++++++
 tb/tb_k007232_mixer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/k007232_mixer.sv
// k007232 output mixer: per-channel 4-bit volume with stepped ramping, 3-stage multiply/sum pipeline.
// Build option: define K007232_MIX_CLIP_EN to saturate the sum instead of wrapping it to OUT_W bits.
module k007232_mixer #(
  parameter int OUT_W      = 12,
  parameter int GAIN_SHIFT = 1,
  parameter int RAMP_DIV   = 16
) (
  input  logic                    CLK,
  input  logic                    NRES,
  input  logic                    SMP_STB,
  input  logic [6:0]              ASD,
  input  logic [6:0]              BSD,
  input  logic                    SLEV,
  input  logic [7:0]              DB,
  output logic signed [OUT_W-1:0] OUT,
  output logic                    OUT_VLD,
  output logic [3:0]              VOL_A,
  output logic [3:0]              VOL_B,
  output logic                    RAMP_BUSY
);

  localparam int RCNT_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(RAMP_DIV - 1);
  localparam logic signed [31:0] SAT_MAX = (32'sd1 <<< (OUT_W - 1)) - 32'sd1;
  localparam logic signed [31:0] SAT_MIN = -(32'sd1 <<< (OUT_W - 1));

  logic              slev_s1_reg, slev_s2_reg, slev_d_reg;
  logic [7:0]        db_s1_reg, db_s2_reg, hold_reg;
  logic [RCNT_W-1:0] rcnt_reg;
  logic              v1_reg, v2_reg, out_vld_reg;
  logic signed [OUT_W-1:0] out_reg;
  logic signed [OUT_W-1:0] out_next;
  logic signed [31:0]      sum_full;

  logic              slev_rise;
  logic              ramp_step;
  logic [1:0][6:0]   smp_bus;
  logic [1:0][3:0]   vol_bus;
  logic [1:0][3:0]   tgt_bus;
  logic [1:0][11:0]  prod_bus;

  // CPU write path: SLEV and DB are both asynchronous, so each gets two flops
  always_ff @(posedge CLK or negedge NRES) begin
    if (!NRES) begin
      slev_s1_reg <= 1'b1;
      slev_s2_reg <= 1'b1;
      slev_d_reg  <= 1'b1;
      db_s1_reg   <= '0;
      db_s2_reg   <= '0;
      hold_reg    <= '0;
    end else begin
      slev_s1_reg <= SLEV;
      slev_s2_reg <= slev_s1_reg;
      slev_d_reg  <= slev_s2_reg;
      db_s1_reg   <= DB;
      db_s2_reg   <= db_s1_reg;
      if (!slev_s2_reg)
        hold_reg <= db_s2_reg;
    end
  end

  assign slev_rise = slev_s2_reg & ~slev_d_reg;
  assign ramp_step = SMP_STB && (rcnt_reg == RCNT_LAST);

  always_ff @(posedge CLK or negedge NRES) begin
    if (!NRES) begin
      rcnt_reg    <= '0;
      v1_reg      <= 1'b0;
      v2_reg      <= 1'b0;
      out_vld_reg <= 1'b0;
      out_reg     <= '0;
    end else begin
      if (SMP_STB)
        rcnt_reg <= ramp_step ? '0 : rcnt_reg + 1'b1;
      v1_reg      <= SMP_STB;
      v2_reg      <= v1_reg;
      out_vld_reg <= v2_reg;
      if (v2_reg)
        out_reg <= out_next;
    end
  end

  assign smp_bus = {BSD, ASD};

  // Channel 0 is A (DB[7:4]), channel 1 is B (DB[3:0])
  for (genvar gi = 0; gi < 2; gi++) begin : g_ch
    logic [3:0]         vol_reg, tgt_reg, va_reg, tgt_wr;
    logic signed [7:0]  sa_reg;
    logic signed [11:0] pa_reg;

    assign tgt_wr = hold_reg[4*(1-gi) +: 4];

    always_ff @(posedge CLK or negedge NRES) begin
      if (!NRES) begin
        tgt_reg <= '0;
        vol_reg <= '0;
        va_reg  <= '0;
        sa_reg  <= '0;
        pa_reg  <= '0;
      end else begin
        if (slev_rise)
          tgt_reg <= tgt_wr;
        // Step compares against the target held before any write landing this cycle
        if (ramp_step && (vol_reg != tgt_reg))
          vol_reg <= (vol_reg < tgt_reg) ? vol_reg + 4'd1 : vol_reg - 4'd1;
        if (SMP_STB) begin
          sa_reg <= $signed({1'b0, smp_bus[gi]} - 8'd64);
          va_reg <= vol_reg;
        end
        if (v1_reg)
          pa_reg <= $signed({{4{sa_reg[7]}}, sa_reg}) * $signed({8'd0, va_reg});
      end
    end

    assign vol_bus[gi]  = vol_reg;
    assign tgt_bus[gi]  = tgt_reg;
    assign prod_bus[gi] = pa_reg;
  end

  always_comb begin
    sum_full = ($signed({{20{prod_bus[0][11]}}, prod_bus[0]}) +
                $signed({{20{prod_bus[1][11]}}, prod_bus[1]})) <<< GAIN_SHIFT;
    out_next = OUT_W'(sum_full);
`ifdef K007232_MIX_CLIP_EN
    if (sum_full > SAT_MAX)
      out_next = OUT_W'(SAT_MAX);
    else if (sum_full < SAT_MIN)
      out_next = OUT_W'(SAT_MIN);
`endif
  end

  assign OUT       = out_reg;
  assign OUT_VLD   = out_vld_reg;
  assign VOL_A     = vol_bus[0];
  assign VOL_B     = vol_bus[1];
  assign RAMP_BUSY = (vol_bus[0] != tgt_bus[0]) || (vol_bus[1] != tgt_bus[1]);

endmodule

// File: tb/tb_k007232_mixer.sv
// Randomised + directed bench for k007232_mixer against an arithmetic reference model.
module tb_k007232_mixer;
  localparam int OUT_W      = 12;
  localparam int GAIN_SHIFT = 1;
  localparam int RAMP_DIV   = 16;

  logic CLK = 1'b0;
  logic NRES, SMP_STB, SLEV;
  logic [6:0] ASD, BSD;
  logic [7:0] DB;
  logic signed [OUT_W-1:0] OUT;
  logic OUT_VLD, RAMP_BUSY;
  logic [3:0] VOL_A, VOL_B;

  k007232_mixer #(.OUT_W(OUT_W), .GAIN_SHIFT(GAIN_SHIFT), .RAMP_DIV(RAMP_DIV)) dut (
    .CLK(CLK), .NRES(NRES), .SMP_STB(SMP_STB), .ASD(ASD), .BSD(BSD),
    .SLEV(SLEV), .DB(DB), .OUT(OUT), .OUT_VLD(OUT_VLD),
    .VOL_A(VOL_A), .VOL_B(VOL_B), .RAMP_BUSY(RAMP_BUSY)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  typedef struct { int due; int val; } exp_t;
  exp_t q[$];
  int cyc = 0;
  int mva = 0, mvb = 0, mtga = 0, mtgb = 0, nstb = 0, mout = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d time=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int mix(input int a, input int b, input int va, input int vb);
    int s;
    s = ((a - 64) * va + (b - 64) * vb) * (1 << GAIN_SHIFT);
`ifdef K007232_MIX_CLIP_EN
    if (s > (1 << (OUT_W - 1)) - 1) s = (1 << (OUT_W - 1)) - 1;
    if (s < -(1 << (OUT_W - 1)))    s = -(1 << (OUT_W - 1));
`else
    s = s & ((1 << OUT_W) - 1);
    if (s >= (1 << (OUT_W - 1))) s = s - (1 << OUT_W);
`endif
    return s;
  endfunction

  function automatic int toward(input int v, input int t);
    if (v < t) return v + 1;
    if (v > t) return v - 1;
    return v;
  endfunction

  // Reference model: counts strobes, steps volumes every RAMP_DIV-th strobe
  always @(posedge CLK) begin
    cyc++;
    if (!NRES) begin
      q.delete();
      mva = 0; mvb = 0; mtga = 0; mtgb = 0; nstb = 0; mout = 0;
    end else if (SMP_STB) begin
      q.push_back('{cyc + 2, mix(int'(ASD), int'(BSD), mva, mvb)});
      nstb = (nstb + 1) % RAMP_DIV;
      if (nstb == 0) begin
        mva = toward(mva, mtga);
        mvb = toward(mvb, mtgb);
      end
    end
  end

  always @(negedge CLK) begin
    if (!NRES) begin
      check("rst_out", int'(OUT), 0);
      check("rst_vld", int'(OUT_VLD), 0);
    end else begin
      automatic int exp_vld = (q.size() > 0 && q[0].due == cyc) ? 1 : 0;
      check("out_vld", int'(OUT_VLD), exp_vld);
      if (exp_vld == 1) begin
        mout = q[0].val;
        void'(q.pop_front());
      end
      check("out", int'(OUT), mout);
      check("vol_a", int'(VOL_A), mva);
      check("vol_b", int'(VOL_B), mvb);
      check("ramp_busy", int'(RAMP_BUSY), (mva != mtga || mvb != mtgb) ? 1 : 0);
    end
  end

  task automatic do_reset();
    @(posedge CLK); #1;
    NRES = 1'b0;
    repeat (3) @(posedge CLK);
    #1 NRES = 1'b1;
  endtask

  task automatic do_write(input logic [7:0] v);
    @(posedge CLK); #1;
    SLEV = 1'b0; DB = v;
    repeat (4) @(posedge CLK);
    #1 SLEV = 1'b1;
    repeat (3) @(posedge CLK);
    #1 mtga = int'(v[7:4]); mtgb = int'(v[3:0]);
  endtask

  task automatic strobe(input logic [6:0] a, input logic [6:0] b);
    @(posedge CLK); #1;
    SMP_STB = 1'b1; ASD = a; BSD = b;
    @(posedge CLK); #1;
    SMP_STB = 1'b0;
  endtask

  task automatic strobes(input int n, input logic [6:0] a, input logic [6:0] b);
    for (int i = 0; i < n; i++) strobe(a, b);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    NRES = 1'b0; SMP_STB = 1'b0; SLEV = 1'b1; DB = 8'h00; ASD = 7'h40; BSD = 7'h40;
    repeat (4) @(posedge CLK);
    #1 NRES = 1'b1;

    // Silence at volume 0
    check("rst_vol_a", int'(VOL_A), 0);
    check("rst_busy", int'(RAMP_BUSY), 0);
    strobes(20, 7'h7F, 7'h7F);
    repeat (3) @(posedge CLK);
    #1 check("silence_out", int'(OUT), 0);

    // Ramp from 0 to A=15, B=8
    do_reset();
    do_write(8'hF8);
    check("busy_after_write", int'(RAMP_BUSY), 1);
    strobes(127, 7'h40, 7'h40);
    check("vol_b_127", int'(VOL_B), 7);
    strobe(7'h40, 7'h40);
    check("vol_b_128", int'(VOL_B), 8);
    strobes(111, 7'h40, 7'h40);
    check("vol_a_239", int'(VOL_A), 14);
    check("busy_239", int'(RAMP_BUSY), 1);
    strobe(7'h40, 7'h40);
    check("vol_a_240", int'(VOL_A), 15);
    check("busy_240", int'(RAMP_BUSY), 0);

    // Mix value and 3-cycle latency
    repeat (4) @(posedge CLK);
    strobe(7'h7F, 7'h40);
    check("lat_vld_1", int'(OUT_VLD), 0);
    @(posedge CLK); #1;
    check("lat_vld_2", int'(OUT_VLD), 0);
    @(posedge CLK); #1;
    check("lat_vld_3", int'(OUT_VLD), 1);
    check("mix_1890", int'(OUT), 1890);

    // Overflow at full volume
    do_write(8'hFF);
    strobes(112, 7'h40, 7'h40);
    check("vol_b_15", int'(VOL_B), 15);
    strobe(7'h00, 7'h00);
    repeat (2) @(posedge CLK);
    #1;
`ifdef K007232_MIX_CLIP_EN
    check("ovf_neg", int'(OUT), -2048);
`else
    check("ovf_neg", int'(OUT), 256);
`endif
    strobe(7'h7F, 7'h7F);
    repeat (2) @(posedge CLK);
    #1;
`ifdef K007232_MIX_CLIP_EN
    check("ovf_pos", int'(OUT), 2047);
`else
    check("ovf_pos", int'(OUT), -316);
`endif

    // Back-to-back strobes
    @(posedge CLK); #1;
    SMP_STB = 1'b1; ASD = 7'h41; BSD = 7'h40;
    @(posedge CLK); #1 ASD = 7'h42;
    @(posedge CLK); #1 ASD = 7'h43;
    @(posedge CLK); #1 SMP_STB = 1'b0;
    check("thru_1", int'(OUT), 15 << GAIN_SHIFT);
    @(posedge CLK); #1;
    check("thru_2", int'(OUT), 30 << GAIN_SHIFT);
    check("thru_2v", int'(OUT_VLD), 1);
    @(posedge CLK); #1;
    check("thru_3", int'(OUT), 45 << GAIN_SHIFT);

    // Retarget mid-ramp
    do_reset();
    do_write(8'hF0);
    strobes(80, 7'h7F, 7'h7F);
    check("retgt_vol5", int'(VOL_A), 5);
    do_write(8'h20);
    strobes(16, 7'h7F, 7'h7F);
    check("retgt_vol4", int'(VOL_A), 4);
    strobes(32, 7'h7F, 7'h7F);
    check("retgt_vol2", int'(VOL_A), 2);
    strobes(20, 7'h7F, 7'h7F);
    check("retgt_hold2", int'(VOL_A), 2);
    repeat (3) @(posedge CLK);
    #1 check("pre_rst_out", int'(OUT), 252);

    // Reset with a sample in flight
    strobe(7'h7F, 7'h7F);
    NRES = 1'b0;
    repeat (2) @(posedge CLK);
    #1 NRES = 1'b1;
    repeat (5) @(posedge CLK);
    #1 check("post_rst_out", int'(OUT), 0);

    // Randomised strobes with concurrent volume writes
    fork
      begin
        for (int i = 0; i < 1500; i++) begin
          @(posedge CLK); #1;
          SMP_STB = ($urandom_range(0, 1) == 1);
          ASD = 7'($urandom);
          BSD = 7'($urandom);
        end
        @(posedge CLK); #1 SMP_STB = 1'b0;
      end
      begin
        for (int w = 0; w < 12; w++) begin
          repeat ($urandom_range(20, 100)) @(posedge CLK);
          do_write(8'($urandom));
        end
      end
    join

    repeat (6) @(posedge CLK);
    #1 check("drain", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
